// File: rtl/mac_skew_feeder_if.sv
// mac_skew_feeder_if: operand handshake and skewed array-edge bus for the skew feeder
interface mac_skew_feeder_if #(
  parameter int D_W = 16,
  parameter int N   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [N*D_W-1:0] in_data;
  logic [N*D_W-1:0] out_data;
  logic [N-1:0]     out_init;
  logic [N-1:0]     out_valid;
  logic             busy;
  logic             done;
  modport master (
    output in_valid, in_last, in_data,
    input  in_ready, out_data, out_init, out_valid, busy, done
  );
  modport slave (
    input  in_valid, in_last, in_data,
    output in_ready, out_data, out_init, out_valid, busy, done
  );
endinterface

// File: rtl/mac_skew_feeder.sv
// mac_skew_feeder: diagonal-skew operand feeder with init flags for an NxN systolic MAC array
module mac_skew_feeder #(
  parameter int D_W = 16,
  parameter int N   = 4
) (
  input logic             clk,
  input logic             rst,
  mac_skew_feeder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;
  localparam int CW = N > 2 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LOAD = CW'(N > 1 ? N - 2 : 0);
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            accept;
  logic            first;
  assign bus.in_ready = rst && state != FLUSH;
  assign accept       = bus.in_valid && bus.in_ready;
  assign first        = state == IDLE || state == DONE;
  assign bus.busy     = state != IDLE;
  assign bus.done     = state == DONE;
  // state and flush counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
  // next state: a last beat waits N-1 cycles in FLUSH so done lines up with it on lane N-1
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, STREAM, DONE: begin
        if (accept && bus.in_last) begin
          state_nxt = N == 1 ? DONE : FLUSH;
          cnt_nxt   = LOAD;
        end else if (accept) state_nxt = STREAM;
        else if (state != STREAM) state_nxt = IDLE;
      end
      FLUSH: begin
        state_nxt = cnt == '0 ? DONE : FLUSH;
        cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [D_W+1:0] sr [0:i];
    // lane i: i+1 stage shift of {valid, init, data}; idle cycles inject a zero bubble
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s <= i; s++) sr[s] <= '0;
      end else begin
        sr[0] <= accept ? {1'b1, first, bus.in_data[i*D_W +: D_W]} : '0;
        for (int s = 1; s <= i; s++) sr[s] <= sr[s-1];
      end
    end
    assign {bus.out_valid[i], bus.out_init[i], bus.out_data[i*D_W +: D_W]} = sr[i];
  end
endmodule

// File: tb/tb_mac_skew_feeder.sv
// tb_mac_skew_feeder: checks N=4, N=1 and N=8 feeders against a beat-history reference model
module tb_mac_skew_feeder;
  localparam int D_W  = 16;
  localparam int MAXC = 1024;
  logic clk = 0;
  logic rst = 1;
  logic vin = 0;
  logic vlast = 0;
  logic [8*D_W-1:0] vdata = '0;
  logic [D_W+1:0] o_lane [3][8];
  logic o_ready [3];
  logic o_busy [3];
  logic o_done [3];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int NN = k == 0 ? 4 : k == 1 ? 1 : 8;
    mac_skew_feeder_if #(.D_W(D_W), .N(NN)) bus ();
    assign bus.in_valid = vin;
    assign bus.in_last  = vlast;
    assign bus.in_data  = vdata[NN*D_W-1:0];
    mac_skew_feeder #(.D_W(D_W), .N(NN)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign o_ready[k] = bus.in_ready;
    assign o_busy[k]  = bus.busy;
    assign o_done[k]  = bus.done;
    for (genvar j = 0; j < 8; j++) begin : g_l
      if (j < NN) begin : g_on
        assign o_lane[k][j] = {bus.out_valid[j], bus.out_init[j], bus.out_data[j*D_W +: D_W]};
      end else begin : g_off
        assign o_lane[k][j] = '0;
      end
    end
  end
  logic [D_W+1:0] ent [3][MAXC][8];
  int t = 0;
  int base = 0;
  int last_e [3];
  bit open [3];
  bit acc [3];
  int nvec = 0;
  int nmis = 0;
  function automatic int nk(int k);
    return k == 0 ? 4 : k == 1 ? 1 : 8;
  endfunction
  task automatic check(string tag, logic [D_W+1:0] obs, logic [D_W+1:0] want);
    nvec++;
    assert (obs === want) else begin
      nmis++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, want);
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ready%0d", k), o_ready[k], t - last_e[k] > nk(k) - 2);
      check($sformatf("busy%0d", k), o_busy[k], open[k] || t - last_e[k] <= nk(k) - 1);
      check($sformatf("done%0d", k), o_done[k], t - last_e[k] == nk(k) - 1);
      for (int j = 0; j < nk(k); j++)
        check($sformatf("lane%0d_%0d", k, j), o_lane[k][j], t - j >= base ? ent[k][t-j][j] : '0);
    end
  endtask
  task automatic step();
    for (int k = 0; k < 3; k++) acc[k] = vin && t - last_e[k] > nk(k) - 2;
    @(posedge clk);
    t++;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++)
        ent[k][t][j] = acc[k] ? {1'b1, !open[k], vdata[j*D_W +: D_W]} : '0;
      if (acc[k]) begin
        open[k] = !vlast;
        if (vlast) last_e[k] = t;
      end
    end
    #1;
    check_all();
  endtask
  task automatic do_reset();
    rst = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready%0d", k), o_ready[k], 1'b0);
      check($sformatf("rst_busy%0d", k), o_busy[k], 1'b0);
      check($sformatf("rst_done%0d", k), o_done[k], 1'b0);
      for (int j = 0; j < nk(k); j++)
        check($sformatf("rst_lane%0d_%0d", k, j), o_lane[k][j], '0);
    end
    @(posedge clk);
    t++;
    @(posedge clk);
    t++;
    @(negedge clk);
    rst = 1;
    base = t + 1;
    for (int k = 0; k < 3; k++) begin
      open[k] = 0;
      last_e[k] = -1000;
    end
    #1;
    check_all();
  endtask
  initial begin
    #2;
    do_reset();
    vin = 1;
    vdata = {64'd0, 16'd4, 16'd3, 16'd2, 16'd1};
    step();
    check("first_lane0", o_lane[0][0], {2'b11, 16'd1});
    vlast = 1;
    vdata = {64'd0, 16'd8, 16'd7, 16'd6, 16'd5};
    step();
    vin = 0;
    vlast = 0;
    repeat (6) step();
    check("idle_after_pass", o_busy[0], 1'b0);
    vin = 1;
    vdata = {$urandom, $urandom, $urandom, $urandom};
    step();
    vin = 0;
    step();
    vin = 1;
    vlast = 1;
    vdata = {$urandom, $urandom, $urandom, $urandom};
    step();
    vin = 0;
    vlast = 0;
    repeat (8) step();
    vin = 1;
    vlast = 1;
    for (int c = 0; c < 20; c++) begin
      vdata = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    vin = 0;
    vlast = 0;
    repeat (9) step();
    vin = 1;
    for (int c = 0; c < 3; c++) begin
      vdata = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    do_reset();
    for (int c = 0; c < 300; c++) begin
      vin = $urandom_range(0, 3) != 0;
      vlast = $urandom_range(0, 5) == 0;
      vdata = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    vin = 0;
    vlast = 0;
    repeat (10) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
